spi_flash_reader: RTL and testbench

//  Synthesizable single-bit SPI master that fetches byte streams from the external SPI flash (bench model spiflash).

---
 rtl/spi_flash_reader.sv | 196 +++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master for a serial boot flash: wakes the device (0xAB) once after reset,
// then serves READ (0x03) requests and streams the bytes out over a valid/ready port.
module spi_flash_reader #(
    parameter int CLK_DIV     = 2,
    parameter int TRES_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        spi_csb,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_WAKE, ST_WAKE_GAP, ST_CMD, ST_ADDR, ST_DATA, ST_GAP, ST_FINISH
    } state_t;

    localparam logic [15:0] DIV_LOAD  = 16'(CLK_DIV - 1);
    localparam logic [15:0] TRES_LOAD = 16'(TRES_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(2 * CLK_DIV - 1);

    state_t      state_r;
    logic [15:0] div_cnt_r;
    logic [15:0] gap_cnt_r;
    logic [15:0] byte_cnt_r;
    logic [4:0]  bit_cnt_r;
    logic [31:0] sh_out_r;
    logic [7:0]  sh_in_r;
    logic [7:0]  rd_data_r;
    logic [23:0] addr_r;
    logic        powered_r;
    logic        last_r;
    logic        csb_r;
    logic        sck_r;
    logic        busy_r;
    logic        done_r;
    logic        rd_valid_r;
    logic [7:0]  rx_byte_s;
    logic        hold_s;

    // Incoming byte and backpressure stall before the first SCK rise of a new byte
    always_comb begin
        rx_byte_s = {sh_in_r[6:0], spi_miso};
        hold_s    = (state_r == ST_DATA) && (bit_cnt_r == 5'd7) && rd_valid_r && !rd_ready;
    end

    // Main sequencer: SCK generation, shifting, byte hand-off and request bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= 16'd0;
            gap_cnt_r  <= 16'd0;
            byte_cnt_r <= 16'd0;
            bit_cnt_r  <= 5'd0;
            sh_out_r   <= 32'd0;
            sh_in_r    <= 8'd0;
            rd_data_r  <= 8'd0;
            addr_r     <= 24'd0;
            powered_r  <= 1'b0;
            last_r     <= 1'b0;
            csb_r      <= 1'b1;
            sck_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (rd_valid_r && rd_ready) begin
                rd_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (len == 16'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            addr_r     <= addr;
                            byte_cnt_r <= len;
                            busy_r     <= 1'b1;
                            csb_r      <= 1'b0;
                            sck_r      <= 1'b0;
                            last_r     <= 1'b0;
                            div_cnt_r  <= DIV_LOAD;
                            bit_cnt_r  <= 5'd7;
                            if (powered_r) begin
                                state_r  <= ST_CMD;
                                sh_out_r <= {8'h03, addr};
                            end else begin
                                state_r  <= ST_WAKE;
                                sh_out_r <= {8'hAB, 24'h000000};
                            end
                        end
                    end
                end
                ST_WAKE, ST_CMD, ST_ADDR, ST_DATA: begin
                    if (div_cnt_r != 16'd0) begin
                        div_cnt_r <= div_cnt_r - 16'd1;
                    end else if (!sck_r) begin
                        // SCK low phase over: either close the window or raise SCK
                        if (last_r) begin
                            csb_r  <= 1'b1;
                            last_r <= 1'b0;
                            if (state_r == ST_WAKE) begin
                                state_r   <= ST_WAKE_GAP;
                                powered_r <= 1'b1;
                                gap_cnt_r <= TRES_LOAD;
                            end else begin
                                state_r   <= ST_GAP;
                                gap_cnt_r <= GAP_LOAD;
                            end
                        end else if (!hold_s) begin
                            sck_r     <= 1'b1;
                            div_cnt_r <= DIV_LOAD;
                            if (state_r == ST_DATA) begin
                                sh_in_r <= rx_byte_s;
                                if (bit_cnt_r == 5'd0) begin
                                    rd_data_r  <= rx_byte_s;
                                    rd_valid_r <= 1'b1;
                                    byte_cnt_r <= byte_cnt_r - 16'd1;
                                end
                            end
                        end
                    end else begin
                        sck_r     <= 1'b0;
                        div_cnt_r <= DIV_LOAD;
                        sh_out_r  <= {sh_out_r[30:0], 1'b0};
                        if (bit_cnt_r != 5'd0) begin
                            bit_cnt_r <= bit_cnt_r - 5'd1;
                        end else begin
                            case (state_r)
                                ST_CMD: begin
                                    state_r   <= ST_ADDR;
                                    bit_cnt_r <= 5'd23;
                                end
                                ST_ADDR: begin
                                    state_r   <= ST_DATA;
                                    bit_cnt_r <= 5'd7;
                                end
                                ST_DATA: begin
                                    if (byte_cnt_r == 16'd0) begin
                                        last_r <= 1'b1;
                                    end else begin
                                        bit_cnt_r <= 5'd7;
                                    end
                                end
                                default: last_r <= 1'b1;
                            endcase
                        end
                    end
                end
                ST_WAKE_GAP: begin
                    if (gap_cnt_r != 16'd0) begin
                        gap_cnt_r <= gap_cnt_r - 16'd1;
                    end else begin
                        state_r   <= ST_CMD;
                        csb_r     <= 1'b0;
                        sh_out_r  <= {8'h03, addr_r};
                        bit_cnt_r <= 5'd7;
                        div_cnt_r <= DIV_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r != 16'd0) begin
                        gap_cnt_r <= gap_cnt_r - 16'd1;
                    end else begin
                        state_r <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (!rd_valid_r || rd_ready) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign spi_csb  = csb_r;
    assign spi_clk  = sck_r;
    assign spi_mosi = sh_out_r[31];
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI flash (0xAB wake, 0x03 read).
module tb_spi_flash_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        spi_csb;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(2), .TRES_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .spi_csb(spi_csb), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    // Flash contents as a closed-form pattern
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [7:0] v;
        v = a[7:0] * 8'd7;
        v = v + a[23:16] + 8'h3C;
        return v;
    endfunction

    int          fl_bits = 0;
    logic [7:0]  fl_cmd  = 8'h00;
    logic [23:0] fl_addr = 24'h0;
    logic [23:0] fl_addr_rx = 24'h0;
    logic [7:0]  fl_out  = 8'h00;
    logic        prev_csb = 1'b1;
    logic        prev_sck = 1'b0;
    int          sck_cnt = 0;
    int          csb_falls = 0;
    logic [7:0]  win_cmd_q[$];
    int          win_bits_q[$];
    logic [23:0] win_addr_q[$];

    // Flash model: one window per CSB-low period, data driven on SCK fall
    always @(spi_csb or spi_clk) begin
        if (prev_csb === 1'b1 && spi_csb === 1'b0) begin
            fl_bits = 0;
            fl_cmd  = 8'h00;
            csb_falls++;
        end
        if (prev_csb === 1'b0 && spi_csb === 1'b1) begin
            win_cmd_q.push_back(fl_cmd);
            win_bits_q.push_back(fl_bits);
            win_addr_q.push_back(fl_addr_rx);
        end
        if (spi_csb === 1'b0 && prev_sck === 1'b0 && spi_clk === 1'b1) begin
            if (fl_bits < 8) fl_cmd = {fl_cmd[6:0], spi_mosi};
            else if (fl_bits < 32) fl_addr = {fl_addr[22:0], spi_mosi};
            fl_bits++;
            sck_cnt++;
            if (fl_bits == 32) fl_addr_rx = fl_addr;
        end
        if (spi_csb === 1'b0 && prev_sck === 1'b1 && spi_clk === 1'b0 &&
            fl_cmd == 8'h03 && fl_bits >= 32) begin
            if ((fl_bits - 32) % 8 == 0) begin
                fl_out  = mem_byte(fl_addr);
                fl_addr = fl_addr + 24'd1;
            end
            spi_miso = fl_out[7];
            fl_out   = {fl_out[6:0], 1'b0};
        end
        prev_csb = spi_csb;
        prev_sck = spi_clk;
    end

    logic [7:0] rx_q[$];
    int         done_cnt = 0;
    int         valid_rises = 0;
    logic       prev_valid = 1'b0;

    // Consumer side monitor
    always @(posedge clk) begin
        if (rd_valid === 1'b1 && rd_ready === 1'b1) rx_q.push_back(rd_data);
        if (done === 1'b1) done_cnt++;
        if (rd_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
        prev_valid = rd_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
        @(negedge clk);
        addr  = a;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_busy_low_with_done"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    task automatic chk_bytes(input string tag, input int base, input int n, input logic [63:0] exp);
        chk({tag, "_byte_count"}, rx_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i),
                (base + i < rx_q.size()) ? {24'h0, rx_q[base + i]} : 32'hDEAD,
                {24'h0, exp[8*(n-1-i) +: 8]});
        end
    endtask

    task automatic chk_win(input string tag, input int idx, input logic [7:0] cmd, input int bits);
        chk({tag, "_cmd"}, (idx < win_cmd_q.size()) ? {24'h0, win_cmd_q[idx]} : 32'hDEAD, {24'h0, cmd});
        chk({tag, "_sck"}, (idx < win_bits_q.size()) ? win_bits_q[idx] : 32'hDEAD, bits);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, wb, cf, vr, s0, n;
        rst_n = 1'b0; start = 1'b0; addr = 24'h0; len = 16'h0; rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("RST_csb", spi_csb, 1'b1);
        chk("RST_sck", spi_clk, 1'b0);
        chk("RST_mosi", spi_mosi, 1'b0);
        chk("RST_busy", busy, 1'b0);
        chk("RST_done", done, 1'b0);
        chk("RST_valid", rd_valid, 1'b0);
        chk("RST_data", rd_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A: first request wakes the flash, then reads 4 bytes from 0
        rb = rx_q.size(); wb = win_cmd_q.size();
        pulse_start(24'h000000, 16'd4);
        chk("A_busy", busy, 1'b1);
        wait_done("A", 3000);
        chk_bytes("A", rb, 4, 64'h3C434A51);
        chk("A_windows", win_cmd_q.size() - wb, 2);
        chk_win("A_wake", wb, 8'hAB, 8);
        chk_win("A_read", wb + 1, 8'h03, 64);
        chk("A_addr", (wb + 1 < win_addr_q.size()) ? win_addr_q[wb + 1] : 24'hDEAD, 24'h000000);

        // B: already powered, no wake
        rb = rx_q.size(); wb = win_cmd_q.size();
        pulse_start(24'h000010, 16'd2);
        wait_done("B", 3000);
        chk_bytes("B", rb, 2, 64'hACB3);
        chk("B_windows", win_cmd_q.size() - wb, 1);
        chk_win("B_read", wb, 8'h03, 48);

        // C: consumer stalls after first byte
        rb = rx_q.size(); wb = win_cmd_q.size();
        pulse_start(24'h000020, 16'd8);
        n = 0;
        while (rx_q.size() < rb + 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("C_first_byte_seen", rx_q.size() >= rb + 1, 1'b1);
        rd_ready = 1'b0;
        repeat (100) @(negedge clk);
        s0 = sck_cnt;
        chk("C_hold_valid", rd_valid, 1'b1);
        chk("C_hold_data", rd_data, 8'h23);
        repeat (100) @(negedge clk);
        chk("C_hold_sck_frozen", sck_cnt, s0);
        chk("C_hold_sck_low", spi_clk, 1'b0);
        chk("C_hold_csb_low", spi_csb, 1'b0);
        rd_ready = 1'b1;
        wait_done("C", 3000);
        chk_bytes("C", rb, 8, 64'h1C232A31383F464D);
        chk("C_windows", win_cmd_q.size() - wb, 1);
        chk_win("C_read", wb, 8'h03, 96);

        // D: wrap at top of address space, second start while busy ignored
        rb = rx_q.size(); wb = win_cmd_q.size();
        pulse_start(24'hFFFFFF, 16'd2);
        repeat (3) @(negedge clk);
        pulse_start(24'h123456, 16'd5);
        wait_done("D", 3000);
        cf = csb_falls;
        repeat (20) @(negedge clk);
        chk("D_no_restart_busy", busy, 1'b0);
        chk("D_no_restart_csb", csb_falls, cf);
        chk_bytes("D", rb, 2, 64'h343C);
        chk("D_windows", win_cmd_q.size() - wb, 1);
        chk_win("D_read", wb, 8'h03, 48);
        chk("D_addr", (wb < win_addr_q.size()) ? win_addr_q[wb] : 24'hDEAD, 24'hFFFFFF);

        // Z: empty request
        cf = csb_falls; vr = valid_rises;
        pulse_start(24'h000040, 16'd0);
        wait_done("Z", 5);
        repeat (10) @(negedge clk);
        chk("Z_no_csb", csb_falls, cf);
        chk("Z_no_valid", valid_rises, vr);

        // R: reset in the middle of the address phase
        pulse_start(24'h000105, 16'd1);
        n = 0;
        while (!(fl_bits >= 12 && spi_clk === 1'b1 && spi_csb === 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("R_reached_addr", fl_bits >= 12, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("R_csb_high", spi_csb, 1'b1);
        chk("R_sck_low", spi_clk, 1'b0);
        chk("R_busy_low", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rb = rx_q.size(); wb = win_cmd_q.size();
        pulse_start(24'h000105, 16'd1);
        wait_done("R", 3000);
        chk_bytes("R", rb, 1, 64'h5F);
        chk("R_windows", win_cmd_q.size() - wb, 2);
        chk_win("R_wake", wb, 8'hAB, 8);
        chk_win("R_read", wb + 1, 8'h03, 40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
